wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
Two-master to one-slave Wishbone classic arbiter for the user project's internal bus. Master 0 is the host-side CPU bridge; master 1 is an on-chip requester such as the USB endpoint engine. The block gives the single slave port to one master at a time, using round-robin arbitration. A bus watchdog aborts stalled transfers.

Parameters:
ADR_W, 14, word address width (byte address bits [1:0] are implicit zero)
DAT_W, 32, data width
SEL_W, 4, byte-select width (DAT_W/8)
TIMEOUT, 255, cycles STB may stay high without ACK before abort; 0 disables the watchdog
TO_W, 8, watchdog counter width; must satisfy TIMEOUT < 2**TO_W

Ports:
clk  in  1  bus clock, rising edge
rst_n  in  1  asynchronous active-low reset
m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe, write enable
m0_adr  in  ADR_W  master 0 address
m0_dat_mosi  in  DAT_W  master 0 write data
m0_sel  in  SEL_W  master 0 byte selects
m0_dat_miso  out  DAT_W  read data to master 0
m0_ack, m0_err  out  1 each  acknowledge / watchdog-abort to master 0
m1_*  (same set as m0_*)  master 1
s_cyc, s_stb, s_we  out  1 each  slave cycle, strobe, write enable
s_adr  out  ADR_W  slave address
s_dat_mosi  out  DAT_W  slave write data
s_sel  out  SEL_W  slave byte selects
s_dat_miso  in  DAT_W  slave read data
s_ack  in  1  slave acknowledge
gnt  out  2  one-hot grant {m1,m0}; 00 = idle
timeout_flag  out  1  sticky; set by any watchdog abort
timeout_clr  in  1  synchronous clear of timeout_flag

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE, gnt=00, last_winner=1 (so m0 wins the first tie).
  - Watchdog counter=0, timeout_flag=0.
  - All s_* outputs and m*_ack/m*_err are 0.
- Grant FSM states: IDLE, G0, G1. gnt is registered and mirrors the state.
- IDLE:
  - Only m0_cyc high -> G0. Only m1_cyc high -> G1.
  - Both high -> the master that is not last_winner.
  - Neither high -> stay IDLE.
- G0 (G1 symmetric):
  - Stay while m0_cyc=1.
  - On m0_cyc=0: go to G1 if m1_cyc=1 (direct handoff, no dead cycle); otherwise go to IDLE.
  - last_winner is updated on entry to a grant state.
- Minimum latency: the cycle after CYC is first sampled high, s_cyc/s_stb follow the winner. The first slave strobe therefore appears one cycle after the request.
- Slave side is combinational from the granted master:
  - s_cyc = m_cyc & grant; s_stb = m_stb & grant & !abort.
  - adr/we/sel/dat_mosi are muxed from the granted master.
  - Outputs are all-zero in IDLE.
- Routing back to masters:
  - s_dat_miso is broadcast to both m*_dat_miso.
  - m*_ack = s_ack & s_stb & gnt[n].
  - An ACK arriving while no STB is presented is dropped.
  - A non-granted master never sees ACK or ERR.
- Watchdog:
  - Counter increments each cycle s_stb=1 and s_ack=0; it clears on s_ack, on s_stb=0, or on any grant change.
  - When the counter == TIMEOUT with no ACK:
    - assert abort for one cycle;
    - pulse m_err to the granted master;
    - force s_stb=0 that cycle;
    - set timeout_flag;
    - clear the counter.
  - The granted master keeps its grant; it is expected to drop STB/CYC on ERR.
  - s_ack in the same cycle as expiry wins: normal ACK, no abort.
- timeout_clr clears the flag next edge. If set and clear coincide, set wins.
- A master dropping CYC mid-transfer, without an ACK, ends the grant immediately. The counter clears and no ERR is generated.
- Fairness: under continuous requests from both masters, grants alternate on each CYC release.
- Reset asserted mid-transfer: all outputs go to 0 immediately (asynchronously).

Test Plan:
1. m0 single read: m0_cyc/stb=1, adr=0x0123; slave acks on 2nd cycle with 0xCAFEF00D -> gnt=01 one cycle after request, s_adr=0x0123, m0_ack=1 with m0_dat_miso=0xCAFEF00D, m1_ack=0 throughout.
2. Simultaneous request after reset: both cyc=1 -> m0 granted first. After m0 drops cyc, gnt=10 on the next edge with no IDLE cycle. Repeat -> m0, m1 alternate.
3. Watchdog: TIMEOUT=4; m1 write, slave never acks -> m1_err pulses exactly 1 cycle after 4 stall cycles, s_stb low that cycle, timeout_flag=1. timeout_clr=1 -> flag 0 next edge.
4. ACK on expiry cycle: TIMEOUT=4, slave acks on the 5th stall cycle -> m_ack=1, no err, flag stays 0.
5. Stray ACK: s_ack=1 while IDLE and while granted with stb=0 -> m0_ack=m1_ack=0.
6. Reset mid-cycle: assert rst_n=0 during a G1 write -> s_cyc, s_stb, gnt and m*_ack drop to 0 without a clock edge; first request after release goes to m0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone classic arbiter.
// A watchdog aborts strobes that stall without an ACK.
module wb_arbiter2 #(
  parameter int ADR_W   = 14,
  parameter int DAT_W   = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [DAT_W-1:0] m0_dat_mosi,
  input  logic [SEL_W-1:0] m0_sel,
  output logic [DAT_W-1:0] m0_dat_miso,
  output logic             m0_ack,
  output logic             m0_err,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [DAT_W-1:0] m1_dat_mosi,
  input  logic [SEL_W-1:0] m1_sel,
  output logic [DAT_W-1:0] m1_dat_miso,
  output logic             m1_ack,
  output logic             m1_err,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [DAT_W-1:0] s_dat_mosi,
  output logic [SEL_W-1:0] s_sel,
  input  logic [DAT_W-1:0] s_dat_miso,
  input  logic             s_ack,
  output logic [1:0]       gnt,
  output logic             timeout_flag,
  input  logic             timeout_clr
);

  // Encoding doubles as the one-hot grant.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   r_flag;
  logic [TO_W-1:0] r_cnt;

  logic w_g0;
  logic w_g1;
  logic w_stb_raw;
  logic w_abort;
  logic w_chg;

  assign w_g0 = (r_state == G0);
  assign w_g1 = (r_state == G1);
  assign w_chg = (w_next != r_state);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || r_last))
          w_next = G0;
        else if (m1_cyc)
          w_next = G1;
      end
      G0: begin
        if (!m0_cyc)
          w_next = m1_cyc ? G1 : IDLE;
      end
      G1: begin
        if (!m1_cyc)
          w_next = m0_cyc ? G0 : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_chg && w_next == G0)
        r_last <= 1'b0;
      else if (w_chg && w_next == G1)
        r_last <= 1'b1;
    end
  end

  assign gnt = r_state;

  assign w_stb_raw = (w_g0 & m0_stb)
                   | (w_g1 & m1_stb);

  // Same-cycle ACK beats expiry.
  assign w_abort = (TIMEOUT != 0)
                 && w_stb_raw
                 && !s_ack
                 && (r_cnt == TO_W'(TIMEOUT));

  assign s_cyc = (w_g0 & m0_cyc)
               | (w_g1 & m1_cyc);
  assign s_stb = w_stb_raw & ~w_abort;

  always_comb begin
    s_we       = 1'b0;
    s_adr      = '0;
    s_dat_mosi = '0;
    s_sel      = '0;
    unique case (1'b1)
      w_g0: begin
        s_we       = m0_we;
        s_adr      = m0_adr;
        s_dat_mosi = m0_dat_mosi;
        s_sel      = m0_sel;
      end
      w_g1: begin
        s_we       = m1_we;
        s_adr      = m1_adr;
        s_dat_mosi = m1_dat_mosi;
        s_sel      = m1_sel;
      end
      default: ;
    endcase
  end

  assign m0_dat_miso = s_dat_miso;
  assign m1_dat_miso = s_dat_miso;
  assign m0_ack = s_ack & s_stb & w_g0;
  assign m1_ack = s_ack & s_stb & w_g1;
  assign m0_err = w_abort & w_g0;
  assign m1_err = w_abort & w_g1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_chg || !s_stb || s_ack)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_flag <= 1'b0;
    else if (w_abort)
      r_flag <= 1'b1;
    else if (timeout_clr)
      r_flag <= 1'b0;
  end

  assign timeout_flag = r_flag;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2.
// Expected master responses go through a queue checked by a monitor.
module tb_wb_arbiter2;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_mosi, m0_dat_miso;
  logic [SW-1:0] m0_sel;
  logic m0_ack, m0_err;
  logic m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_mosi, m1_dat_miso;
  logic [SW-1:0] m1_sel;
  logic m1_ack, m1_err;
  logic s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_mosi, s_dat_miso;
  logic [SW-1:0] s_sel;
  logic s_ack;
  logic [1:0] gnt;
  logic timeout_flag, timeout_clr;

  always #5 clk = ~clk;

  wb_arbiter2 #(
    .ADR_W(AW), .DAT_W(DW), .SEL_W(SW),
    .TIMEOUT(4), .TO_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb),
    .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_mosi(m0_dat_mosi),
    .m0_sel(m0_sel),
    .m0_dat_miso(m0_dat_miso),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb),
    .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_mosi(m1_dat_mosi),
    .m1_sel(m1_sel),
    .m1_dat_miso(m1_dat_miso),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb),
    .s_we(s_we), .s_adr(s_adr),
    .s_dat_mosi(s_dat_mosi),
    .s_sel(s_sel),
    .s_dat_miso(s_dat_miso),
    .s_ack(s_ack), .gnt(gnt),
    .timeout_flag(timeout_flag),
    .timeout_clr(timeout_clr)
  );

  typedef struct {
    logic        ch;
    logic        err;
    logic [31:0] dat;
  } rsp_t;

  rsp_t q[$];
  int checks = 0;
  int fails = 0;

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic ch, logic err,
                      logic [31:0] dat);
    rsp_t r;
    r.ch = ch;
    r.err = err;
    r.dat = dat;
    q.push_back(r);
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m0_adr = '0; m0_dat_mosi = '0;
    m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    m1_adr = '0; m1_dat_mosi = '0;
    m1_sel = '0;
    s_ack = 0; s_dat_miso = '0;
    timeout_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  // Monitor: every master-side response must match the queue head.
  always @(negedge clk) begin
    rsp_t r;
    logic ch, e;
    if (rst_n === 1'b1 &&
        (m0_ack | m1_ack | m0_err | m1_err)) begin
      ch = m1_ack | m1_err;
      e = m0_err | m1_err;
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp ack=%b%b err=%b%b exp=none",
                 m1_ack, m0_ack, m1_err, m0_err);
      end else begin
        r = q.pop_front();
        chk("rsp_onehot",
            64'(m0_ack + m1_ack + m0_err + m1_err),
            64'd1);
        chk("rsp_ch", 64'(ch), 64'(r.ch));
        chk("rsp_err", 64'(e), 64'(r.err));
        if (!r.err)
          chk("rsp_dat", 64'(m0_dat_miso),
              64'(r.dat));
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_scyc", 64'(s_cyc), 64'd0);
    chk("rst_sstb", 64'(s_stb), 64'd0);
    chk("rst_flag", 64'(timeout_flag), 64'd0);

    // 1: m0 single read
    m0_cyc = 1; m0_stb = 1;
    m0_adr = 14'h0123; m0_sel = 4'hF;
    #1;
    chk("t1_lat_gnt", 64'(gnt), 64'd0);
    chk("t1_lat_stb", 64'(s_stb), 64'd0);
    tick();
    chk("t1_gnt", 64'(gnt), 64'h1);
    chk("t1_stb", 64'(s_stb), 64'd1);
    chk("t1_adr", 64'(s_adr), 64'h0123);
    chk("t1_we", 64'(s_we), 64'd0);
    tick();
    push(1'b0, 1'b0, 32'hCAFEF00D);
    s_ack = 1; s_dat_miso = 32'hCAFEF00D;
    #1;
    chk("t1_ack", 64'(m0_ack), 64'd1);
    chk("t1_bcast", 64'(m1_dat_miso),
        64'hCAFEF00D);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t1_idle", 64'(gnt), 64'd0);

    // 2: simultaneous requests alternate
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("t2_first", 64'(gnt), 64'h1);
    for (int i = 0; i < 3; i++) begin
      m0_cyc = 0;
      tick();
      chk("t2_to_m1", 64'(gnt), 64'h2);
      m0_cyc = 1;
      tick();
      chk("t2_hold_m1", 64'(gnt), 64'h2);
      m1_cyc = 0;
      tick();
      chk("t2_to_m0", 64'(gnt), 64'h1);
      m1_cyc = 1;
      tick();
    end
    idle_inputs();
    tick();

    // 3: watchdog abort on m1 write
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    m1_adr = 14'h2AAA;
    m1_dat_mosi = 32'h12345678;
    m1_sel = 4'hA;
    tick();
    chk("t3_gnt", 64'(gnt), 64'h2);
    chk("t3_we", 64'(s_we), 64'd1);
    chk("t3_adr", 64'(s_adr), 64'h2AAA);
    chk("t3_dat", 64'(s_dat_mosi),
        64'h12345678);
    chk("t3_sel", 64'(s_sel), 64'hA);
    for (int i = 0; i < 4; i++) tick();
    push(1'b1, 1'b1, 32'h0);
    chk("t3_err", 64'(m1_err), 64'd1);
    chk("t3_stb_low", 64'(s_stb), 64'd0);
    chk("t3_keep", 64'(gnt), 64'h2);
    tick();
    chk("t3_flag", 64'(timeout_flag), 64'd1);
    chk("t3_err_1cyc", 64'(m1_err), 64'd0);
    chk("t3_stb_back", 64'(s_stb), 64'd1);
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    tick();
    chk("t3_flag_hold", 64'(timeout_flag),
        64'd1);
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    chk("t3_flag_clr", 64'(timeout_flag),
        64'd0);

    // 4: ACK on expiry cycle wins
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    m0_adr = 14'h0042;
    tick();
    for (int i = 0; i < 4; i++) tick();
    push(1'b0, 1'b0, 32'hA5A55A5A);
    s_ack = 1; s_dat_miso = 32'hA5A55A5A;
    #1;
    chk("t4_ack", 64'(m0_ack), 64'd1);
    chk("t4_noerr", 64'(m0_err), 64'd0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t4_flag", 64'(timeout_flag), 64'd0);

    // 5: stray ACKs are dropped
    do_reset();
    s_ack = 1;
    #1;
    chk("t5_idle_a0", 64'(m0_ack), 64'd0);
    chk("t5_idle_a1", 64'(m1_ack), 64'd0);
    m0_cyc = 1;
    tick();
    chk("t5_gnt", 64'(gnt), 64'h1);
    chk("t5_nostb_a0", 64'(m0_ack), 64'd0);
    chk("t5_nostb_a1", 64'(m1_ack), 64'd0);
    idle_inputs();
    tick();

    // 6: async reset mid-transfer
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    tick();
    chk("t6_gnt", 64'(gnt), 64'h2);
    chk("t6_scyc", 64'(s_cyc), 64'd1);
    #1;
    rst_n = 0;
    s_ack = 1;
    #1;
    chk("t6_r_scyc", 64'(s_cyc), 64'd0);
    chk("t6_r_sstb", 64'(s_stb), 64'd0);
    chk("t6_r_gnt", 64'(gnt), 64'd0);
    chk("t6_r_ack", 64'(m1_ack), 64'd0);
    tick();
    idle_inputs();
    rst_n = 1;
    tick();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    chk("t6_first", 64'(gnt), 64'h1);
    idle_inputs();
    tick();
    tick();

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
